// File: rtl/multicycle_pkg.sv
// Shared types, opcode/funct constants and instruction field helpers for multicycle_core.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [5:0] ir_op(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] ir_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] ir_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] ir_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [5:0] ir_funct(input logic [31:0] ir);
        return ir[5:0];
    endfunction

    function automatic logic [15:0] ir_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    function automatic logic [25:0] ir_jidx(input logic [31:0] ir);
        return ir[25:0];
    endfunction

endpackage

// File: rtl/multicycle_alu.sv
// Combinational ALU: add/sub/and/or/signed-slt with a zero flag for branch compares.
module multicycle_alu
    import multicycle_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] y,
    output logic              zero
);

    // Operation select; arithmetic wraps modulo 2^DATA_W
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y[0] = ($signed(a) < $signed(b));
            default: y = a + b;
        endcase
        zero = (y == '0);
    end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle MIPS-style core sharing one req/ready memory port for fetch and data.
// Optional performance counters are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_core
    import multicycle_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter int                REG_COUNT = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    localparam int               RD_W      = (DATA_W > 32) ? DATA_W : 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [RD_W-1:0]   mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] result,
    output logic              halted,
    output logic              error
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_count
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] wb_val_q, wb_val_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [4:0]        dest_q, dest_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] regs_d [REG_COUNT];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;
    logic [31:0]       br_off32, jt32;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic [DATA_W-1:0] alu_b, alu_y;
    alu_op_e           alu_op;
    logic              alu_zero;
    logic              funct_ok;
    logic              req_int;

    assign op       = ir_op(ir_q);
    assign funct    = ir_funct(ir_q);
    assign rs       = ir_rs(ir_q);
    assign rt       = ir_rt(ir_q);
    assign rd       = ir_rd(ir_q);
    assign imm16    = ir_imm(ir_q);
    assign imm_ext  = DATA_W'($signed(imm16));
    assign br_off32 = {{14{imm16[15]}}, imm16, 2'b00};
    assign jt32     = {4'b0000, ir_jidx(ir_q), 2'b00};

    // Register file read ports; r0 and unimplemented indices read as zero
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && int'(rs) < REG_COUNT) rs_val = regs_q[rs];
        if (rt != 5'd0 && int'(rt) < REG_COUNT) rt_val = regs_q[rt];
    end

    // ALU control: operation and second operand per opcode/funct
    always_comb begin
        alu_op   = ALU_ADD;
        alu_b    = b_q;
        funct_ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                funct_ok = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: funct_ok = 1'b0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_b = imm_ext;
            OP_BEQ, OP_BNE:        alu_op = ALU_SUB;
            default: ;
        endcase
    end

    multicycle_alu #(.DATA_W(DATA_W)) u_alu (
        .a    (a_q),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Control FSM next-state, datapath register updates and memory port drive
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        wb_val_d = wb_val_q;
        result_d = result_q;
        dest_d   = dest_q;
        error_d  = error_q;
        regs_d   = regs_q;
        req_int  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_q;
        case (state_q)
            FETCH: begin
                req_int = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                state_d = EXEC;
            end
            EXEC: begin
                case (op)
                    OP_RTYPE: begin
                        if (funct_ok) begin
                            wb_val_d = alu_y;
                            dest_d   = rd;
                            state_d  = WB;
                        end else begin
                            error_d = 1'b1;
                            state_d = HALT;
                        end
                    end
                    OP_ADDI: begin
                        wb_val_d = alu_y;
                        dest_d   = rt;
                        state_d  = WB;
                    end
                    OP_LW, OP_SW: begin
                        addr_d  = ADDR_W'(alu_y);
                        dest_d  = rt;
                        state_d = MEM;
                    end
                    OP_BEQ: begin
                        if (alu_zero) pc_d = pc_q + br_off32[ADDR_W-1:0];
                        state_d = FETCH;
                    end
                    OP_BNE: begin
                        if (!alu_zero) pc_d = pc_q + br_off32[ADDR_W-1:0];
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pc_d    = jt32[ADDR_W-1:0];
                        state_d = FETCH;
                    end
                    OP_HALT: state_d = HALT;
                    default: begin
                        error_d = 1'b1;
                        state_d = HALT;
                    end
                endcase
            end
            MEM: begin
                req_int  = 1'b1;
                mem_addr = addr_q;
                mem_we   = (op == OP_SW);
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        state_d = FETCH;
                    end else begin
                        wb_val_d = mem_rdata[DATA_W-1:0];
                        state_d  = WB;
                    end
                end
            end
            WB: begin
                if (dest_q != 5'd0 && int'(dest_q) < REG_COUNT) regs_d[dest_q] = wb_val_q;
                result_d = wb_val_q;
                state_d  = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Request is masked while reset is held so an in-flight access is dropped at once
    assign mem_req   = req_int & ~reset;
    assign mem_wdata = b_q;
    assign result    = result_q;
    assign halted    = (state_q == HALT);
    assign error     = error_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            addr_q   <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wb_val_q <= '0;
            result_q <= '0;
            dest_q   <= '0;
            error_q  <= 1'b0;
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wb_val_q <= wb_val_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            error_q  <= error_d;
            regs_q   <= regs_d;
        end
    end

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;

    // Cycle count runs outside HALT; instruction retires on return to FETCH or entry to HALT
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (state_q != HALT) cycle_d = cycle_q + 32'd1;
        if (state_q != HALT && state_q != FETCH && (state_d == FETCH || state_d == HALT))
            instr_d = instr_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Directed self-checking bench for multicycle_core (RESET_PC=0x40, 32-bit data).
module tb_multicycle_core;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = '0, result;
    logic        halted, error;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    multicycle_core #(
        .DATA_W    (32),
        .ADDR_W    (16),
        .REG_COUNT (32),
        .RESET_PC  (16'h0040)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .result    (result),
        .halted    (halted),
        .error     (error)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    always #5 clock = ~clock;

    // Memory model and observers, evaluated on the falling edge
    logic [31:0] mem [64];
    int          latency = 0;
    int          wait_cnt = 0;
    bit          pend = 0;
    logic [15:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    int          stab_err = 0;
    int          req_halted = 0;
    logic [31:0] prev_res = '0;
    logic [31:0] res_log [$];
    logic [15:0] rd_log [$];
    logic [15:0] wr_addr_log [$];
    logic [31:0] wr_data_log [$];

    always @(negedge clock) begin
        if (reset) begin
            pend = 0;
            wait_cnt = 0;
            mem_ready = 1'b0;
        end else begin
            if (pend && (!mem_req || mem_addr !== s_addr || mem_we !== s_we ||
                         (s_we && mem_wdata !== s_wdata)))
                stab_err++;
            mem_ready = 1'b0;
            pend = 0;
            if (mem_req) begin
                if (wait_cnt >= latency) begin
                    mem_ready = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) begin
                        mem[mem_addr[7:2]] = mem_wdata;
                        wr_addr_log.push_back(mem_addr);
                        wr_data_log.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr[7:2]];
                        rd_log.push_back(mem_addr);
                    end
                end else begin
                    wait_cnt++;
                    pend = 1;
                    s_addr = mem_addr;
                    s_we = mem_we;
                    s_wdata = mem_wdata;
                end
            end else begin
                wait_cnt = 0;
            end
            if (halted && mem_req) req_halted++;
            if (result !== prev_res) begin
                res_log.push_back(result);
                prev_res = result;
            end
        end
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int idx);
        return {6'(op), 26'(idx)};
    endfunction

    localparam logic [31:0] HALT_W = {6'h3F, 26'h0};

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        mem[(addr >> 2) & 63] = w;
    endtask

    // Hold reset for two edges, then release just after a rising edge with clean logs
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        res_log.delete();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
        prev_res = '0;
        stab_err = 0;
        req_halted = 0;
    endtask

    task automatic run_to_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 9));
        put(16'h44, HALT_W);
        do_reset();
        run_to_halt(50, cyc);
        reset = 1'b1;
        @(posedge clock);
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        @(posedge clock);
        #1;
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result got=%0h exp=0", result); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got=%b exp=0", halted); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error got=%b exp=0", error); end
        reset = 1'b0;
        res_log.delete();
        rd_log.delete();
        prev_res = '0;
        #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got=%b exp=1", mem_req); end
        vectors++; if (mem_addr !== 16'h0040) begin miscompares++; $display("FAIL first_addr got=%0h exp=40", mem_addr); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL first_we got=%b exp=0", mem_we); end
        run_to_halt(50, cyc);
    endtask

    task automatic test_arith();
        int cyc;
        logic [31:0] exp [4];
        exp = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd1};
        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 5));
        put(16'h44, enc_i(8, 0, 2, -3));
        put(16'h48, enc_r(1, 2, 3, 'h20));
        put(16'h4C, enc_r(2, 1, 4, 'h2A));
        put(16'h50, HALT_W);
        do_reset();
        run_to_halt(100, cyc);
        vectors++; if (cyc !== 19) begin miscompares++; $display("FAIL arith_cycles got=%0d exp=19", cyc); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL arith_halted got=%b exp=1", halted); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL arith_error got=%b exp=0", error); end
        vectors++; if (result !== 32'd1) begin miscompares++; $display("FAIL arith_result got=%0h exp=1", result); end
        vectors++; if (res_log.size() !== 4) begin miscompares++; $display("FAIL arith_wb_count got=%0d exp=4", res_log.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= res_log.size() || res_log[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL arith_wb%0d got=%0h exp=%0h", i, (i < res_log.size()) ? res_log[i] : 32'hx, exp[i]);
            end
        end
`ifdef MULTICYCLE_PERF_CNT_EN
        vectors++; if (cycle_count !== 32'd19) begin miscompares++; $display("FAIL perf_cycles got=%0d exp=19", cycle_count); end
        vectors++; if (instr_count !== 32'd5) begin miscompares++; $display("FAIL perf_instr got=%0d exp=5", instr_count); end
`endif
        repeat (5) @(posedge clock);
        #1;
        vectors++; if (req_halted !== 0) begin miscompares++; $display("FAIL halt_req got=%0d exp=0", req_halted); end
`ifdef MULTICYCLE_PERF_CNT_EN
        vectors++; if (cycle_count !== 32'd19) begin miscompares++; $display("FAIL perf_freeze got=%0d exp=19", cycle_count); end
`endif
    endtask

    task automatic test_alu_ops();
        int cyc;
        logic [31:0] exp [6];
        exp = '{32'h0F0F, 32'h00FF, 32'h000F, 32'h0FFF, 32'hFFFF_F1F0, 32'h0};
        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 'h0F0F));
        put(16'h44, enc_i(8, 0, 2, 'h00FF));
        put(16'h48, enc_r(1, 2, 3, 'h24));
        put(16'h4C, enc_r(1, 2, 4, 'h25));
        put(16'h50, enc_r(2, 1, 5, 'h22));
        put(16'h54, enc_r(1, 2, 6, 'h2A));
        put(16'h58, HALT_W);
        do_reset();
        run_to_halt(100, cyc);
        vectors++; if (res_log.size() !== 6) begin miscompares++; $display("FAIL alu_wb_count got=%0d exp=6", res_log.size()); end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (i >= res_log.size() || res_log[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL alu_wb%0d got=%0h exp=%0h", i, (i < res_log.size()) ? res_log[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_mem_wait();
        int cyc;
        logic [31:0] exp [4];
        exp = '{32'd5, 32'd0, 32'd5, 32'd10};
        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 5));
        put(16'h44, enc_i('h2B, 0, 1, 8));
        put(16'h48, enc_i(8, 0, 1, 0));
        put(16'h4C, enc_i('h23, 0, 5, 8));
        put(16'h50, enc_r(5, 5, 6, 'h20));
        put(16'h54, HALT_W);
        latency = 3;
        do_reset();
        run_to_halt(200, cyc);
        latency = 0;
        vectors++; if (cyc !== 48) begin miscompares++; $display("FAIL mem_cycles got=%0d exp=48", cyc); end
        vectors++; if (wr_addr_log.size() !== 1) begin miscompares++; $display("FAIL mem_wr_count got=%0d exp=1", wr_addr_log.size()); end
        vectors++; if (wr_addr_log.size() < 1 || wr_addr_log[0] !== 16'h0008) begin miscompares++; $display("FAIL mem_wr_addr got=%0h exp=8", (wr_addr_log.size() > 0) ? wr_addr_log[0] : 16'hx); end
        vectors++; if (wr_data_log.size() < 1 || wr_data_log[0] !== 32'd5) begin miscompares++; $display("FAIL mem_wr_data got=%0h exp=5", (wr_data_log.size() > 0) ? wr_data_log[0] : 32'hx); end
        vectors++; if (stab_err !== 0) begin miscompares++; $display("FAIL mem_stable got=%0d exp=0", stab_err); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= res_log.size() || res_log[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL mem_wb%0d got=%0h exp=%0h", i, (i < res_log.size()) ? res_log[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        int cyc;
        logic [15:0] e_loop [4];
        logic [15:0] e_nt [3];
        logic [15:0] e_tk [3];
        e_loop = '{16'h40, 16'h10, 16'h10, 16'h10};
        e_nt   = '{16'h40, 16'h10, 16'h14};
        e_tk   = '{16'h40, 16'h44, 16'h4C};

        clear_mem();
        put(16'h40, enc_j(2, 4));
        put(16'h10, enc_i(4, 1, 1, -1));
        put(16'h14, HALT_W);
        do_reset();
        repeat (12) @(posedge clock);
        #1;
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL beq_loop_halted got=%b exp=0", halted); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= rd_log.size() || rd_log[i] !== e_loop[i]) begin
                miscompares++;
                $display("FAIL beq_fetch%0d got=%0h exp=%0h", i, (i < rd_log.size()) ? rd_log[i] : 16'hx, e_loop[i]);
            end
        end

        clear_mem();
        put(16'h40, enc_j(2, 4));
        put(16'h10, enc_i(5, 1, 1, 4));
        put(16'h14, HALT_W);
        do_reset();
        run_to_halt(50, cyc);
        vectors++; if (error !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL bne_nt_status got=%b%b exp=10", error, halted); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= rd_log.size() || rd_log[i] !== e_nt[i]) begin
                miscompares++;
                $display("FAIL bne_nt_fetch%0d got=%0h exp=%0h", i, (i < rd_log.size()) ? rd_log[i] : 16'hx, e_nt[i]);
            end
        end

        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 1));
        put(16'h44, enc_i(5, 1, 0, 1));
        put(16'h48, enc_i(8, 0, 2, 2));
        put(16'h4C, HALT_W);
        do_reset();
        run_to_halt(50, cyc);
        vectors++; if (rd_log.size() !== 3) begin miscompares++; $display("FAIL bne_tk_count got=%0d exp=3", rd_log.size()); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (i >= rd_log.size() || rd_log[i] !== e_tk[i]) begin
                miscompares++;
                $display("FAIL bne_tk_fetch%0d got=%0h exp=%0h", i, (i < rd_log.size()) ? rd_log[i] : 16'hx, e_tk[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int cyc;
        clear_mem();
        put(16'h40, {6'h3E, 26'h0});
        do_reset();
        run_to_halt(50, cyc);
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL ill_op_error got=%b exp=1", error); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL ill_op_halted got=%b exp=1", halted); end
        repeat (3) @(posedge clock);
        #1;
        vectors++; if (req_halted !== 0) begin miscompares++; $display("FAIL ill_halt_req got=%0d exp=0", req_halted); end

        clear_mem();
        put(16'h40, enc_r(1, 2, 3, 'h21));
        do_reset();
        run_to_halt(50, cyc);
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL ill_fn_error got=%b exp=1", error); end
        vectors++; if (res_log.size() !== 0) begin miscompares++; $display("FAIL ill_fn_wb got=%0d exp=0", res_log.size()); end
    endtask

    task automatic test_r0();
        int cyc;
        logic [31:0] exp [2];
        exp = '{32'd7, 32'd0};
        clear_mem();
        put(16'h40, enc_i(8, 0, 0, 7));
        put(16'h44, enc_r(0, 0, 7, 'h20));
        put(16'h48, HALT_W);
        do_reset();
        run_to_halt(50, cyc);
        vectors++; if (res_log.size() !== 2) begin miscompares++; $display("FAIL r0_wb_count got=%0d exp=2", res_log.size()); end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (i >= res_log.size() || res_log[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL r0_wb%0d got=%0h exp=%0h", i, (i < res_log.size()) ? res_log[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        bit found = 0;
        clear_mem();
        put(16'h40, enc_i(8, 0, 1, 3));
        put(16'h44, enc_i('h23, 0, 2, 8));
        put(16'h48, HALT_W);
        put(16'h08, 32'h1234);
        latency = 4;
        do_reset();
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clock);
            #1;
            if (mem_req === 1'b1 && mem_addr === 16'h0008) found = 1;
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_lw_seen got=0 exp=1"); end
        reset = 1'b1;
        @(posedge clock);
        #1;
        latency = 0;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_lw_req got=%b exp=0", mem_req); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL mid_lw_result got=%0h exp=0", result); end
`ifdef MULTICYCLE_PERF_CNT_EN
        vectors++; if (cycle_count !== 32'd0) begin miscompares++; $display("FAIL mid_lw_cycles got=%0d exp=0", cycle_count); end
        vectors++; if (instr_count !== 32'd0) begin miscompares++; $display("FAIL mid_lw_instr got=%0d exp=0", instr_count); end
`endif
        vectors++; if (wr_addr_log.size() !== 0) begin miscompares++; $display("FAIL mid_lw_write got=%0d exp=0", wr_addr_log.size()); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_arith();
        test_alu_ops();
        test_mem_wait();
        test_branch();
        test_illegal();
        test_r0();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath top.
- Same MIPS-style 32-bit instruction format. Execution is sequenced by a control FSM, not hard-tied control lines.
- Fetch and data access share one memory port with a req/ready handshake, so slow memories are tolerated.
- Exposes the last write-back value plus halt/error status for board-level observation.

Parameters:
- DATA_W, 32, register/ALU/data width (>=16).
- ADDR_W, 16, byte-address width of PC and memory port (<=32).
- REG_COUNT, 32, implemented registers (2..32). Indices >= REG_COUNT read 0 and ignore writes. r0 always reads 0.
- RESET_PC, 0, PC value after reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory access request, held until mem_ready.
- mem_we  out  1  1 = write (sw), 0 = read.
- mem_addr  out  ADDR_W  byte address (PC on fetch, ALU result on lw/sw).
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  max(32,DATA_W)  read data; bits [31:0] used on fetch.
- mem_ready  in  1  access complete this cycle; rdata valid.
- result  out  DATA_W  value of the most recent register write-back.
- halted  out  1  core stopped.
- error  out  1  stopped on an illegal opcode/funct.

Behaviour:
- Reset, evaluated at a clock edge: pc=RESET_PC, state=FETCH, all registers=0, result=0, halted=0, error=0, mem_req=0. Reset mid-access drops mem_req the next cycle; no register write occurs.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: ir<=rdata[31:0], pc<=pc+4 (wraps mod 2^ADDR_W), go to DECODE.
- DECODE: A<=R[rs], B<=R[rt]; imm sign-extended to DATA_W. Go to EXEC.
- EXEC, per opcode:
  - R-type (op 0x00): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1). Go to WB with dest=rd.
  - addi (0x08): A+imm, go to WB with dest=rt.
  - lw (0x23) / sw (0x2B): addr<=A+imm (low ADDR_W bits), go to MEM.
  - beq (0x04) / bne (0x05): if taken, pc<=pc+(imm<<2), where pc already equals the instruction address +4. Go to FETCH.
  - j (0x02): pc<={imm26,2'b00} truncated to ADDR_W. Go to FETCH.
  - halt (0x3F): go to HALT.
  - Anything else: error<=1, go to HALT.
- MEM: mem_req=1, mem_addr=addr, mem_we=(sw), mem_wdata=B.
  - sw: on mem_ready, go to FETCH.
  - lw: on mem_ready, mdr<=rdata[DATA_W-1:0], go to WB with dest=rt.
- WB: if dest!=0 and dest<REG_COUNT, write R[dest]. result<=value regardless of dest. Go to FETCH.
- HALT: halted=1, mem_req=0. Stays until reset.
- mem_req, mem_we, mem_addr and mem_wdata stay stable while waiting for mem_ready. mem_ready while mem_req=0 is ignored.
- Arithmetic wraps modulo 2^DATA_W. No overflow traps.
- Cycle counts with zero-wait memory (mem_ready in the first req cycle):
  - R-type / addi: 4.
  - lw: 5.
  - sw: 4.
  - branch / jump: 3.
  - Each wait cycle adds 1.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_count [31:0] (increments every non-HALT cycle) and instr_count [31:0] (increments on each transition back to FETCH or into HALT).
  - Both clear on reset, wrap at 2^32, and freeze in HALT.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum;
  - opcode/funct localparams;
  - ALU-op enum (ADD, SUB, AND, OR, SLT);
  - the instruction field-slicing helpers.
- One sub-module, multicycle_alu: combinational, DATA_W-parametrised, two operands + ALU-op → result and zero flag.
- Register file, FSM and datapath registers stay in multicycle_core.

Test Plan:
- Reset with RESET_PC=0x40, zero-wait memory → first mem_addr=0x40, registers 0, result=0.
- Program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1; halt → result=1 after slt, R3=2, halted=1 with no further mem_req, total 4+4+4+4+3=19 cycles.
- sw r1,8(r0) then lw r5,8(r0), with mem_ready delayed 3 cycles per access → write of 5 seen at addr 8, R5=5, address/data held stable through the waits.
- beq r1,r1,-1 at 0x10 → next fetch addr 0x10 (loop). bne r1,r1,+4 → falls through to 0x14.
- Illegal opcode 0x3E → error=1, halted=1. Write to r0 → R0 stays 0 while result shows the computed value.
- With MULTICYCLE_PERF_CNT_EN: the 5-instruction program → instr_count=5, cycle_count=19. Reset asserted mid-lw → both counters and mem_req clear next cycle.
